gaussian_window_feeder: RTL and testbench
=========================================

# gaussian_window_feeder

Upstream stage of the Gaussian-blur divider in the Canny/Hough pipeline. Reads 8-bit grayscale pixels in raster order from an input FIFO and keeps four line buffers plus a 5x5 window. For each pixel it forms the 5x5 Gaussian weighted sum and hands it to the unsigned divider (divisor 159), then writes the 8-bit quotient to an output FIFO. Output pixel count equals input pixel count per frame; border positions emit 0 without using the divider.

## Interface
- Clocking: reset reset, asynchronous, active-high; clock clk.
- IMG_WIDTH, 720: pixels per row.
- IMG_HEIGHT, 540: rows per frame.
- clk  in  1  clock
- reset  in  1  async active-high reset
- in_empty  in  1  input FIFO empty
- in_dout  in  8  input FIFO data, valid with in_rd_en
- in_rd_en  out  1  input FIFO pop
- out_full  in  1  output FIFO full
- out_wr_en  out  1  output FIFO push
- out_din  out  8  blurred pixel
- div_valid_in  out  1  one-cycle start pulse to divider
- div_dividend  out  16  weighted sum
- div_divisor  out  8  constant 159
- div_quotient  in  16  divider result
- div_valid_out  in  1  divider result valid, one cycle

## Operation
- Kernel rows: 2 4 5 4 2 / 4 9 12 9 4 / 5 12 15 12 5 / 4 9 12 9 4 / 2 4 5 4 2; sum 159.
  - Max sum is 255*159=40545, so it fits 16 bits unsigned with no saturation.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the pixel being processed.
- Window: output at input (r,c) uses input rows r-4..r and cols c-4..c.
- Border: if r<4 or c<4, output 0 and skip the divider.
- States:
  - S_READ: if !in_empty, assert in_rd_en.
    - Shift the window left one column; new right column = {lb3[col], lb2[col], lb1[col], lb0[col], in_dout}, oldest row first.
    - Update line buffers: lb3[col]<=lb2[col], lb2<=lb1, lb1<=lb0, lb0[col]<=in_dout.
    - Go to S_SUM.
  - S_SUM: register the weighted sum into the dividend register.
    - Border: result<=0, go to S_WRITE.
    - Otherwise: go to S_DIV.
  - S_DIV: div_valid_in=1 for exactly this cycle; go to S_WAIT.
  - S_WAIT: on div_valid_out, result<=div_quotient[7:0] and go to S_WRITE. div_quotient[15:8] is always 0 and is ignored.
  - S_WRITE: if !out_full, assert out_wr_en with out_din=result and advance counters.
    - At col=IMG_WIDTH-1, col wraps to 0 and row increments.
    - At the last pixel, both counters wrap to 0 (next frame).
    - Go to S_READ.
- div_dividend is driven from the dividend register at all times. div_divisor is tied to 159.
- The pixel stream must never stall the divider mid-operation: div_valid_in is issued only from S_DIV, and the divider's INIT wait accepts it.

## Timing
- Reset values:
  - Outputs: in_rd_en, out_wr_en, div_valid_in = 0; out_din = 0; div_dividend = 0; div_divisor = 159.
  - Internal: state S_READ; col, row, window, result all 0.
  - Line buffers are not reset; border gating guarantees stale data never reaches the output.
- Border pixel: 3 cycles minimum (READ, SUM, WRITE).
- Interior pixel: 4 cycles + divider latency (div_valid_in to div_valid_out).
- in_rd_en and out_wr_en are never both high; at most one FIFO action per cycle.
- Backpressure: out_full holds the block in S_WRITE with out_din stable; no reads occur.
- Empty input holds the block in S_READ with no side effects.
- Reset mid-frame or mid-divide aborts immediately. The divider shares the reset, so no stale div_valid_out reaches this block. The next pixel accepted is treated as (0,0).
- Frame wrap: the first four rows of every frame are border, so the previous frame's line-buffer contents never contaminate the output.

## Structure
- Package gaussian_pkg holds:
  - the kernel weight constant array
  - KERNEL_SUM=159
  - the state enum (S_READ, S_SUM, S_DIV, S_WAIT, S_WRITE)
- Natural sub-module: gaussian_line_buffer, one IMG_WIDTH x 8 synchronous array with read/write at the same address.
  - The top instantiates four of them.
  - Read-before-write semantics at the same address are required.
- The divider stays external; the top level wires it.

## Test plan
- IMG_WIDTH=8, IMG_HEIGHT=8, all pixels 100 -> rows 0-3 and cols 0-3 output 0; every other output 100 (15900/159); exactly 64 writes.
- All pixels 255 -> interior 255 (40545/159), dividend observed 40545; border 0.
- Zero image with 255 at (2,2):
  - output (4,4)=24 (3825/159)
  - output (4,5)=19 (3060/159)
  - output (4,6)=8 (1275/159)
  - output (5,4)=19
- out_full held high 5 cycles in S_WRITE -> out_wr_en 0, out_din stable, in_rd_en 0; a single write follows release.
- Two uniform frames of 100 then 50 back-to-back -> second frame rows 0-3 are 0, interior exactly 50; no values from frame 1.
- Reset asserted during S_WAIT of an interior pixel -> all outputs return to reset values next edge; a fresh frame of 100s reproduces the first test exactly.

Source files
------------

// File: rtl/gaussian_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gaussian_pkg
//  Purpose  : Shared constants, kernel weights and FSM encoding for the
//             Gaussian window feeder.
//  Revision : 1.0 - initial release
// ============================================================================
package gaussian_pkg;

    localparam int PIX_W      = 8;
    localparam int KERNEL_SUM = 159;
    localparam int KSIZE      = 5;

    // Row 0 is the oldest image row in the window, column 4 the newest pixel.
    localparam logic [3:0] KERNEL_WEIGHTS [0:KSIZE-1][0:KSIZE-1] = '{
        '{4'd2, 4'd4,  4'd5,  4'd4,  4'd2},
        '{4'd4, 4'd9,  4'd12, 4'd9,  4'd4},
        '{4'd5, 4'd12, 4'd15, 4'd12, 4'd5},
        '{4'd4, 4'd9,  4'd12, 4'd9,  4'd4},
        '{4'd2, 4'd4,  4'd5,  4'd4,  4'd2}
    };

    typedef enum logic [2:0] {
        S_READ  = 3'd0,
        S_SUM   = 3'd1,
        S_DIV   = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gaussian_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : gaussian_line_buffer
//  Purpose  : One image row of pixel storage; combinational read and clocked
//             write at a shared address, so a write cycle reads the old value.
//  Revision : 1.0 - initial release
// ============================================================================
module gaussian_line_buffer
    import gaussian_pkg::*;
#(
    parameter int DEPTH  = 720,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] r_mem [0:DEPTH-1];

    assign rd_data = r_mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gaussian_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : gaussian_window_feeder
//  Purpose  : 5x5 Gaussian window over a raster pixel stream; feeds the
//             weighted sum to an external divider and writes the quotient.
//  Revision : 1.0 - initial release
// ============================================================================
module gaussian_window_feeder
    import gaussian_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_empty,
    input  logic [7:0]  in_dout,
    output logic        in_rd_en,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [7:0]  out_din,
    output logic        div_valid_in,
    output logic [15:0] div_dividend,
    output logic [7:0]  div_divisor,
    input  logic [15:0] div_quotient,
    input  logic        div_valid_out
);

    localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int BORDER = KSIZE - 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [PIX_W-1:0]  r_window [0:KSIZE-1][0:KSIZE-1];
    logic [PIX_W-1:0]  w_new_col [0:KSIZE-1];
    logic [PIX_W-1:0]  w_lb_rd [0:BORDER-1];
    logic [PIX_W-1:0]  w_lb_wr [0:BORDER-1];
    logic [15:0]       r_dividend;
    logic [15:0]       w_sum;
    logic [PIX_W-1:0]  r_result;
    logic              w_rd;
    logic              w_wr;
    logic              w_div_start;
    logic              w_border;
    logic              w_unused_quot_hi;

    // Line buffers form a vertical shift chain: lb0 holds row r-1, lb3 row r-4.
    assign w_lb_wr[0] = in_dout;

    generate
        for (genvar k = 1; k < BORDER; k++) begin : g_chain
            assign w_lb_wr[k] = w_lb_rd[k-1];
        end
        for (genvar k = 0; k < BORDER; k++) begin : g_line_buf
            gaussian_line_buffer #(
                .DEPTH  (IMG_WIDTH),
                .ADDR_W (COL_W)
            ) u_lb (
                .clk     (clk),
                .wr_en   (w_rd),
                .addr    (r_col),
                .wr_data (w_lb_wr[k]),
                .rd_data (w_lb_rd[k])
            );
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < BORDER; i++) begin
            w_new_col[i] = w_lb_rd[BORDER-1-i];
        end
        w_new_col[BORDER] = in_dout;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                w_sum = w_sum + 16'(KERNEL_WEIGHTS[i][j]) * 16'(r_window[i][j]);
            end
        end
    end

    assign w_border = (r_row < ROW_W'(BORDER)) || (r_col < COL_W'(BORDER));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_READ;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        w_div_start  = 1'b0;
        case (r_state)
            S_READ: begin
                if (!in_empty) begin
                    w_rd         = 1'b1;
                    w_next_state = S_SUM;
                end
            end
            S_SUM:   w_next_state = w_border ? S_WRITE : S_DIV;
            S_DIV: begin
                w_div_start  = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (div_valid_out) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!out_full) begin
                    w_wr         = 1'b1;
                    w_next_state = S_READ;
                end
            end
            default: w_next_state = S_READ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_dividend <= '0;
            r_result   <= '0;
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    r_window[i][j] <= '0;
                end
            end
        end else begin
            if (w_rd) begin
                for (int i = 0; i < KSIZE; i++) begin
                    for (int j = 0; j < KSIZE-1; j++) begin
                        r_window[i][j] <= r_window[i][j+1];
                    end
                    r_window[i][KSIZE-1] <= w_new_col[i];
                end
            end
            if (r_state == S_SUM) begin
                r_dividend <= w_sum;
                if (w_border) begin
                    r_result <= '0;
                end
            end
            if (r_state == S_WAIT && div_valid_out) begin
                r_result <= div_quotient[7:0];
            end
            if (w_wr) begin
                if (r_col == COL_W'(IMG_WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Quotient never exceeds 255, so the upper byte carries no information.
    assign w_unused_quot_hi = |div_quotient[15:8];

    assign in_rd_en     = w_rd && !reset;
    assign out_wr_en    = w_wr && !reset;
    assign out_din      = r_result;
    assign div_valid_in = w_div_start;
    assign div_dividend = r_dividend;
    assign div_divisor  = 8'(KERNEL_SUM);

endmodule
`default_nettype wire

// File: tb/tb_gaussian_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gaussian_window_feeder
//  Purpose  : Directed self-checking bench on an 8x8 image with FIFO and
//             divider models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gaussian_window_feeder;

    localparam int W       = 8;
    localparam int H       = 8;
    localparam int NPIX    = W * H;
    localparam int DIV_LAT = 3;
    localparam int TIMEOUT = 5000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_empty = 1'b1;
    logic [7:0]  in_dout = 8'd0;
    logic        in_rd_en;
    logic        out_full = 1'b0;
    logic        out_wr_en;
    logic [7:0]  out_din;
    logic        div_valid_in;
    logic [15:0] div_dividend;
    logic [7:0]  div_divisor;
    logic [15:0] div_quotient = 16'd0;
    logic        div_valid_out = 1'b0;

    gaussian_window_feeder #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_empty      (in_empty),
        .in_dout       (in_dout),
        .in_rd_en      (in_rd_en),
        .out_full      (out_full),
        .out_wr_en     (out_wr_en),
        .out_din       (out_din),
        .div_valid_in  (div_valid_in),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_valid_out (div_valid_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  in_q [$];
    logic [7:0]  out_q [$];
    logic [7:0]  frames [0:5][0:NPIX-1];
    int          wr_count = 0;
    int          div_starts = 0;
    int          overlap_cnt = 0;
    int          div_cnt = 0;
    logic [15:0] div_hold = 16'd0;
    logic [15:0] last_dividend = 16'd0;

    typedef struct {
        int frame;
        int r;
        int c;
        int exp;
    } vec_t;
    vec_t vecs [$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Upstream FIFO, downstream FIFO and divider models.
    always @(posedge clk) begin
        if (!reset) begin
            if (in_rd_en && in_q.size() > 0) void'(in_q.pop_front());
            if (out_wr_en) begin
                out_q.push_back(out_din);
                wr_count++;
            end
            if (in_rd_en && out_wr_en) overlap_cnt++;
            if (div_valid_in) begin
                div_starts++;
                last_dividend = div_dividend;
                div_hold      = div_dividend / 16'd159;
                div_cnt       = DIV_LAT;
            end
        end
    end

    always @(negedge clk) begin
        in_empty = (in_q.size() == 0);
        in_dout  = (in_q.size() > 0) ? in_q[0] : 8'd0;
        if (reset) begin
            div_cnt       = 0;
            div_valid_out = 1'b0;
        end else if (div_cnt == 1) begin
            div_valid_out = 1'b1;
            div_quotient  = div_hold;
            div_cnt       = 0;
        end else begin
            div_valid_out = 1'b0;
            if (div_cnt > 1) div_cnt--;
        end
    end

    task automatic push_frame(input int kind, input logic [7:0] v);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (kind == 0) in_q.push_back(v);
                else           in_q.push_back((r == 2 && c == 2) ? 8'd255 : 8'd0);
            end
        end
    endtask

    task automatic collect(input int f);
        int n;
        n = 0;
        while (out_q.size() < NPIX && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("frame%0d_complete", f), (out_q.size() >= NPIX) ? 1 : 0, 1);
        for (int i = 0; i < NPIX; i++) begin
            frames[f][i] = (out_q.size() > 0) ? out_q.pop_front() : 8'd0;
        end
    endtask

    task automatic check_uniform(input int f, input int v);
        for (int i = 0; i < NPIX; i++) begin
            check($sformatf("frame%0d_px_r%0d_c%0d", f, i / W, i % W), frames[f][i],
                  ((i / W) < 4 || (i % W) < 4) ? 0 : v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_rd_en"},     in_rd_en,     0);
        check({tag, "_out_wr_en"},    out_wr_en,    0);
        check({tag, "_div_valid_in"}, div_valid_in, 0);
        check({tag, "_out_din"},      out_din,      0);
        check({tag, "_div_dividend"}, div_dividend, 0);
        check({tag, "_div_divisor"},  div_divisor,  159);
    endtask

    initial begin
        int n;
        int base;

        // frame, row, col, expected output
        vecs.push_back('{0, 0, 0, 0});
        vecs.push_back('{0, 3, 7, 0});
        vecs.push_back('{0, 7, 3, 0});
        vecs.push_back('{0, 4, 4, 100});
        vecs.push_back('{0, 5, 6, 100});
        vecs.push_back('{0, 7, 7, 100});
        vecs.push_back('{1, 4, 4, 255});
        vecs.push_back('{1, 7, 7, 255});
        vecs.push_back('{1, 2, 5, 0});
        vecs.push_back('{2, 4, 4, 24});
        vecs.push_back('{2, 4, 5, 19});
        vecs.push_back('{2, 4, 6, 8});
        vecs.push_back('{2, 5, 4, 19});
        vecs.push_back('{2, 6, 6, 3});
        vecs.push_back('{2, 4, 7, 0});
        vecs.push_back('{2, 7, 4, 0});
        vecs.push_back('{4, 0, 0, 0});
        vecs.push_back('{4, 3, 6, 0});
        vecs.push_back('{4, 4, 4, 50});
        vecs.push_back('{4, 4, 5, 50});
        vecs.push_back('{4, 7, 7, 50});

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        push_frame(0, 8'd100);
        collect(0);
        repeat (20) @(negedge clk);
        check("f0_write_count", wr_count, 64);
        check("f0_div_starts", div_starts, 16);

        push_frame(0, 8'd255);
        collect(1);
        check("f1_dividend", last_dividend, 40545);

        push_frame(1, 8'd0);
        collect(2);

        push_frame(0, 8'd100);
        push_frame(0, 8'd50);
        collect(3);
        collect(4);

        foreach (vecs[k]) begin
            check($sformatf("vec%0d_f%0d_r%0d_c%0d", k, vecs[k].frame, vecs[k].r, vecs[k].c),
                  frames[vecs[k].frame][vecs[k].r * W + vecs[k].c], vecs[k].exp);
        end
        check_uniform(0, 100);
        check_uniform(4, 50);

        // Backpressure: stall on interior pixel (4,4) of a fresh frame of 100s.
        for (int i = 0; i < 38; i++) in_q.push_back(8'd100);
        n = 0;
        while (out_q.size() < 36 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_36", out_q.size(), 36);
        out_full = 1'b1;
        repeat (15) @(negedge clk);
        base = wr_count;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_wr_en", out_wr_en, 0);
            check("bp_in_rd_en", in_rd_en, 0);
            check("bp_out_din", out_din, 100);
            @(negedge clk);
        end
        check("bp_no_read", in_q.size(), 1);
        check("bp_no_write", wr_count, base);
        out_full = 1'b0;
        #1;
        check("bp_release_wr_en", out_wr_en, 1);
        @(negedge clk);
        check("bp_single_write", wr_count, base + 1);
        check("bp_written_value", (out_q.size() > 0) ? int'(out_q[out_q.size()-1]) : -1, 100);

        // Reset while waiting on the divider for pixel (4,5).
        n = 0;
        while (!div_valid_in && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("rst_div_started", div_valid_in, 1);
        check("rst_still_one_write", wr_count, base + 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_q.delete();
        #1;
        check_reset_outputs("rst_wait");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_wait_edge");
        @(negedge clk);
        reset = 1'b0;
        base = wr_count;
        repeat (10) @(negedge clk);
        check("rst_no_stale_write", wr_count, base);
        out_q.delete();
        push_frame(0, 8'd100);
        collect(5);
        check_uniform(5, 100);

        check("fifo_overlap", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
